// File: rtl/adder_seq.sv
// Multi-cycle adder: walks a SLICE-bit ripple adder across WIDTH-bit operands, LSB slice first.
// Define ADDSEQ_SUB_EN to honour the sub input (two's-complement a - b).
module adder_seq #(
    parameter int WIDTH = 12,
    parameter int SLICE = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  b_eff;
    logic              carry;
    logic              carry_init;
    logic [IDXW-1:0]   idx;
    logic [SLICE:0]    slice_sum;
    logic              last_slice;
    logic              accept;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state == RUN);
    assign accept     = in_valid && (state == IDLE);
    assign last_slice = (idx == IDXW'(NSLICE - 1));

`ifdef ADDSEQ_SUB_EN
    logic sub_r;

    // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
    assign b_eff      = sub_r ? ~b_r : b_r;
    assign carry_init = sub;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sub_r <= 1'b0;
        end else if (accept) begin
            sub_r <= sub;
        end
    end
`else
    logic unused_sub;

    assign b_eff      = b_r;
    assign carry_init = 1'b0;
    assign unused_sub = sub;
`endif

    always_comb begin
        slice_sum = {1'b0, a_r[idx*SLICE +: SLICE]}
                  + {1'b0, b_eff[idx*SLICE +: SLICE]}
                  + {{SLICE{1'b0}}, carry};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sum bits are only overwritten slice by slice, so the previous result stays visible until the next run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            carry <= carry_init;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[idx*SLICE +: SLICE] <= slice_sum[SLICE-1:0];
            carry                   <= slice_sum[SLICE];
            if (last_slice) begin
                sum[WIDTH] <= slice_sum[SLICE];
                idx        <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq: directed corner cases plus random operations against an arithmetic model.
// Honours ADDSEQ_SUB_EN the same way the design does.
module tb_adder_seq;

    localparam int W  = 12;
    localparam int S  = 3;
    localparam int NS = W / S;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   sum;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    adder_seq #(.WIDTH(W), .SLICE(S)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] modelSum(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        logic [W:0] r;
        r = {1'b0, av} + {1'b0, bv};
`ifdef ADDSEQ_SUB_EN
        if (sv) r = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
`else
        if (sv) r = {1'b0, av} + {1'b0, bv};
`endif
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [W:0] observed, input logic [W:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One full transaction: accept, run with scrambled inputs, optional backpressure, then release.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input int hold);
        logic [W:0] expected;
        int edges;
        int busyCnt;
        expected  = modelSum(av, bv, sv);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        sub       = sv;
        out_ready = (hold == 0);
        checkOutput("in_ready_idle", (W+1)'(in_ready), (W+1)'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        sub      = 1'($urandom);
        edges    = 0;
        busyCnt  = 0;
        while (!out_valid && edges < 4*NS + 8) begin
            if (busy && !in_ready) busyCnt++;
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("latency", (W+1)'(edges), (W+1)'(NS));
        checkOutput("busy_cycles", (W+1)'(busyCnt), (W+1)'(NS));
        checkOutput("sum", sum, expected);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", (W+1)'(out_valid), (W+1)'(1));
            checkOutput("hold_in_ready", (W+1)'(in_ready), (W+1)'(0));
            checkOutput("hold_sum", sum, expected);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("release_valid", (W+1)'(out_valid), (W+1)'(0));
        checkOutput("release_in_ready", (W+1)'(in_ready), (W+1)'(1));
        checkOutput("sum_kept", sum, expected);
        out_ready = 1'($urandom);
    endtask

    initial begin
        logic [W:0] lastSum;
        logic       sawValid;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", (W+1)'(in_ready), (W+1)'(1));
        checkOutput("reset_out_valid", (W+1)'(out_valid), (W+1)'(0));
        checkOutput("reset_busy", (W+1)'(busy), (W+1)'(0));
        checkOutput("reset_sum", sum, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset two edges into a run must abort it completely.
        in_valid = 1'b1;
        a        = 12'h5A3;
        b        = 12'h2C4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("pre_abort_busy", (W+1)'(busy), (W+1)'(1));
        reset_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", (W+1)'(out_valid), (W+1)'(0));
        checkOutput("abort_busy", (W+1)'(busy), (W+1)'(0));
        checkOutput("abort_in_ready", (W+1)'(in_ready), (W+1)'(1));
        checkOutput("abort_sum", sum, '0);
        @(posedge clk); #1;
        reset_n  = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("abort_no_valid", (W+1)'(sawValid), (W+1)'(0));

        applyStimulus(12'h5A3, 12'h2C4, 1'b0, 0);
        applyStimulus(12'hFFF, 12'h001, 1'b0, 0);
        applyStimulus(12'h7FF, 12'h7FF, 1'b0, 5);
        applyStimulus(12'h100, 12'h001, 1'b1, 0);
        applyStimulus(12'h001, 12'h002, 1'b1, 1);

        // Idle with in_valid low: nothing moves even while operands wiggle.
        lastSum  = sum;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk); #1;
        end
        checkOutput("idle_sum", sum, lastSum);
        checkOutput("idle_busy", (W+1)'(busy), (W+1)'(0));
        checkOutput("idle_in_ready", (W+1)'(in_ready), (W+1)'(1));

        for (int n = 0; n < 16; n++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_seq.md
Name: adder_seq

Overview:
- Multi-cycle controller that sequences a narrow ripple-carry adder slice across wide operands, least-significant slice first, with the carry held in a flop between slices.
- Operands enter through a valid/ready handshake. The full result is presented through a second valid/ready handshake.
- Sits between an operand source (register file or test stimulus) and a result consumer. Lets a 3-bit gate-level adder serve arbitrary-width additions.

Parameters:
- WIDTH, 12, operand width in bits; must be a multiple of SLICE and at least SLICE.
- SLICE, 3, bits added per cycle (width of the adder slice).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a, b, sub are valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  1 = compute a - b; only honoured with ADDSEQ_SUB_EN
- out_valid  out  1  sum is valid
- out_ready  in  1  consumer accepts sum
- sum  out  WIDTH+1  result; bit WIDTH is the final carry-out
- busy  out  1  high in RUN state

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - sum = 0; carry flop = 0; slice index = 0.
  - Any in-flight operation is discarded.
- Constant NSLICE = WIDTH/SLICE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: latch a and b into operand registers, latch sub, carry = 0 (1 when subtracting), index = 0, go to RUN.
- RUN:
  - in_ready = 0; busy = 1.
  - Each edge computes slice index i with the combinational ripple formula: s = a_r[i] + b_eff[i] + carry. b_eff is b_r, or ~b_r when subtracting.
  - Write s[SLICE-1:0] to sum bits [i*SLICE +: SLICE], carry = s[SLICE], index increments.
  - On the edge processing slice NSLICE-1: sum[WIDTH] = carry-out, go to DONE, out_valid = 1.
- DONE:
  - out_valid = 1; sum is held stable; in_ready = 0.
  - On an edge with out_ready = 1: go to IDLE, out_valid = 0. sum keeps its value until the next accept.
- Latency: out_valid rises exactly NSLICE edges after the accepting edge (4 for the defaults). Throughput is one operation per NSLICE+2 cycles minimum.
- No back-to-back accept in the DONE cycle; in_ready is low until the state returns to IDLE.
- Operand inputs changing during RUN/DONE have no effect; only the latched copies are used.
- in_valid low in IDLE: remain in IDLE, no register changes.
- out_ready high outside DONE: ignored.
- Arithmetic is modulo 2^WIDTH in bits [WIDTH-1:0]. Bit WIDTH is the unsigned carry-out.

Optional Feature:
- Macro: ADDSEQ_SUB_EN
- Defined:
  - The sub input is latched on accept.
  - sub = 1 uses the inverted B operand and an initial carry of 1, giving two's-complement a - b.
  - sum[WIDTH] = 1 means no borrow (a >= b unsigned); sum[WIDTH] = 0 means borrow.
- Undefined:
  - sub is ignored and the block always adds.
  - No inverter or carry-in mux is synthesised.

Test Plan:
- Reset during RUN (assert reset_n = 0 two cycles after accepting a = 0x5A3, b = 0x2C4) -> immediately out_valid = 0, busy = 0, in_ready = 1, sum = 0. No out_valid appears after release.
- a = 0x5A3, b = 0x2C4, out_ready = 1 -> out_valid exactly 4 edges after accept, sum = 0x0867, busy high for 4 cycles, in_ready = 1 one cycle after completion.
- a = 0xFFF, b = 0x001 -> carry ripples through every slice, sum = 0x1000.
- Backpressure: a = 0x7FF, b = 0x7FF with out_ready = 0 for 5 cycles -> sum = 0x0FFE held stable, out_valid held, in_ready = 0 throughout. Releases one cycle after out_ready = 1.
- ADDSEQ_SUB_EN defined, sub = 1:
  - a = 0x100, b = 0x001 -> sum = 0x10FF.
  - a = 0x001, b = 0x002 -> sum = 0x0FFF.
- ADDSEQ_SUB_EN undefined, sub = 1, a = 0x100, b = 0x001 -> sum = 0x0101.
